// File: rtl/filter_ctrl_pkg.sv
// Shared types for the filter control path: sequencer states, configuration record, mode codes.
package filter_ctrl_pkg;

  localparam int unsigned THR_W = 8;

  localparam logic MODE_PASSTHROUGH = 1'b0;
  localparam logic MODE_FILTER      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PENDING = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_ARM     = 3'd3,
    ST_COMMIT  = 3'd4
  } state_e;

  typedef struct packed {
    logic             mode;
    logic             gaussian;
    logic             sobel;
    logic [THR_W-1:0] threshold;
  } cfg_t;

  // Saturate a requested threshold to the supported maximum.
  function automatic logic [THR_W-1:0] clamp_thr(input logic [THR_W-1:0] thr,
                                                 input logic [THR_W-1:0] lim);
    return (thr > lim) ? lim : thr;
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// Request/shadow/active configuration storage for the frame sequencer.
// Requests are registered and clamped once; shadow follows them unless frozen; active loads on commit.
module cfg_shadow_reg
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned THR_DEFAULT = 25,
  parameter int unsigned THR_MAX     = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cfg_t             i_req,
  input  logic             i_load,
  input  logic             i_commit,
  output logic             o_mode,
  output logic             o_gaussian_en,
  output logic             o_sobel_en,
  output logic [THR_W-1:0] o_threshold,
  output logic             o_diff_c
);

  localparam cfg_t CFG_RESET = '{
    mode:      MODE_PASSTHROUGH,
    gaussian:  1'b0,
    sobel:     1'b0,
    threshold: THR_W'(THR_DEFAULT)
  };

  cfg_t req_q, req_d;
  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;
  logic gaussian_en_q, gaussian_en_d;
  logic sobel_en_q, sobel_en_d;

  always_comb begin
    req_d           = i_req;
    req_d.threshold = clamp_thr(i_req.threshold, THR_W'(THR_MAX));
    shadow_d        = i_load ? req_q : shadow_q;
    active_d        = i_commit ? shadow_q : active_q;
    // Enables reach the datapath only in filter mode.
    gaussian_en_d   = active_d.gaussian & (active_d.mode == MODE_FILTER);
    sobel_en_d      = active_d.sobel & (active_d.mode == MODE_FILTER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= CFG_RESET;
      shadow_q      <= CFG_RESET;
      active_q      <= CFG_RESET;
      gaussian_en_q <= 1'b0;
      sobel_en_q    <= 1'b0;
    end else begin
      req_q         <= req_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      gaussian_en_q <= gaussian_en_d;
      sobel_en_q    <= sobel_en_d;
    end
  end

  assign o_diff_c      = (shadow_q != active_q);
  assign o_mode        = active_q.mode;
  assign o_threshold   = active_q.threshold;
  assign o_gaussian_en = gaussian_en_q;
  assign o_sobel_en    = sobel_en_q;

endmodule

// File: rtl/frame_cfg_sequencer.sv
// Frame-synchronous filter configuration sequencer: flushes the pipeline and commits changes at SOF.
// Optional drain watchdog enabled by defining CFG_DRAIN_TIMEOUT_EN; threshold width comes from filter_ctrl_pkg.
module frame_cfg_sequencer
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned THR_DEFAULT = 25,
  parameter int unsigned THR_MAX     = 100
`ifdef CFG_DRAIN_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input  logic             i_sysclk,
  input  logic             RST,
  input  logic             i_req_mode,
  input  logic             i_req_gaussian,
  input  logic             i_req_sobel,
  input  logic [THR_W-1:0] i_req_threshold,
  input  logic             i_sof,
  input  logic             i_eof,
  input  logic             i_pipe_idle,
  output logic             o_mode,
  output logic             o_gaussian_en,
  output logic             o_sobel_en,
  output logic [THR_W-1:0] o_threshold,
  output logic             o_pipe_flush,
  output logic             o_busy,
  output logic             o_applied,
  output logic             o_drain_timeout
);

  state_e state_q, state_d;
  logic   pipe_flush_q, pipe_flush_d;
  logic   busy_q, busy_d;
  logic   applied_q, applied_d;
  logic   diff_c, load_c, commit_c, timeout_c;
  cfg_t   req_c;

  assign req_c = '{
    mode:      i_req_mode,
    gaussian:  i_req_gaussian,
    sobel:     i_req_sobel,
    threshold: i_req_threshold
  };

  // Shadow is frozen only in the commit cycle; active loads on the edge after SOF in ARM.
  assign load_c   = (state_q != ST_COMMIT);
  assign commit_c = (state_q == ST_ARM) && i_sof;

  cfg_shadow_reg #(
    .THR_DEFAULT (THR_DEFAULT),
    .THR_MAX     (THR_MAX)
  ) u_shadow (
    .clk           (i_sysclk),
    .rst_n         (RST),
    .i_req         (req_c),
    .i_load        (load_c),
    .i_commit      (commit_c),
    .o_mode        (o_mode),
    .o_gaussian_en (o_gaussian_en),
    .o_sobel_en    (o_sobel_en),
    .o_threshold   (o_threshold),
    .o_diff_c      (diff_c)
  );

`ifdef CFG_DRAIN_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             drain_timeout_q, drain_timeout_d;

  // Watchdog counts DRAIN cycles and clears whenever DRAIN is left.
  assign timeout_c = (state_q == ST_DRAIN) && !i_pipe_idle &&
                     (drain_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    drain_cnt_d     = '0;
    drain_timeout_d = timeout_c;
    if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
      drain_cnt_d = drain_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      drain_cnt_q     <= drain_cnt_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign o_drain_timeout = drain_timeout_q;
`else
  assign timeout_c       = 1'b0;
  assign o_drain_timeout = 1'b0;
`endif

  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pipe_flush_d = 1'b0;
    busy_d       = 1'b0;
    applied_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (diff_c) begin
          state_d = i_eof ? ST_DRAIN : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!diff_c) begin
          state_d = ST_IDLE;
        end else if (i_eof) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_pipe_idle || timeout_c) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (i_sof) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Status outputs are registered views of the state being entered.
    pipe_flush_d = (state_d == ST_DRAIN) || (state_d == ST_ARM);
    busy_d       = (state_d == ST_PENDING) || (state_d == ST_DRAIN) || (state_d == ST_ARM);
    applied_d    = (state_d == ST_COMMIT);
  end

  always_ff @(posedge i_sysclk or negedge RST) begin
    if (!RST) begin
      pipe_flush_q <= 1'b0;
      busy_q       <= 1'b0;
      applied_q    <= 1'b0;
    end else begin
      pipe_flush_q <= pipe_flush_d;
      busy_q       <= busy_d;
      applied_q    <= applied_d;
    end
  end

  assign o_pipe_flush = pipe_flush_q;
  assign o_busy       = busy_q;
  assign o_applied    = applied_q;

endmodule

// File: tb/tb_frame_cfg_sequencer.sv
// Self-checking bench for frame_cfg_sequencer: behavioural model compared every cycle plus directed literal checks.
// Define CFG_DRAIN_TIMEOUT_EN to also exercise the drain watchdog with TIMEOUT_CYC=16.
module tb_frame_cfg_sequencer;

  localparam int THR_DEF = 25;
  localparam int THR_LIM = 100;
  localparam int TO_CYC  = 16;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_DRAIN  = 2;
  localparam int PH_ARM    = 3;
  localparam int PH_COMMIT = 4;

  logic       clk;
  logic       rst_n;
  logic       req_mode, req_gauss, req_sobel;
  logic [7:0] req_thr;
  logic       sof, eof, pipe_idle;
  logic       o_mode, o_gaussian_en, o_sobel_en, o_pipe_flush, o_busy, o_applied, o_drain_timeout;
  logic [7:0] o_threshold;

  int n_vec  = 0;
  int n_miss = 0;
  int applied_cnt = 0;
  int flush_cnt   = 0;

`ifdef CFG_DRAIN_TIMEOUT_EN
  frame_cfg_sequencer #(.THR_DEFAULT(THR_DEF), .THR_MAX(THR_LIM), .TIMEOUT_CYC(TO_CYC)) dut (
`else
  frame_cfg_sequencer #(.THR_DEFAULT(THR_DEF), .THR_MAX(THR_LIM)) dut (
`endif
    .i_sysclk        (clk),
    .RST             (rst_n),
    .i_req_mode      (req_mode),
    .i_req_gaussian  (req_gauss),
    .i_req_sobel     (req_sobel),
    .i_req_threshold (req_thr),
    .i_sof           (sof),
    .i_eof           (eof),
    .i_pipe_idle     (pipe_idle),
    .o_mode          (o_mode),
    .o_gaussian_en   (o_gaussian_en),
    .o_sobel_en      (o_sobel_en),
    .o_threshold     (o_threshold),
    .o_pipe_flush    (o_pipe_flush),
    .o_busy          (o_busy),
    .o_applied       (o_applied),
    .o_drain_timeout (o_drain_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Configuration encoded as one integer: mode<<10 | gaussian<<9 | sobel<<8 | clamped threshold.
  function automatic int pack_cfg(input logic m, input logic g, input logic s, input logic [7:0] t);
    int thr;
    thr = (int'(t) > THR_LIM) ? THR_LIM : int'(t);
    return (int'(m) << 10) | (int'(g) << 9) | (int'(s) << 8) | thr;
  endfunction

  localparam int CFG_RST = THR_DEF;

  int m_req    = CFG_RST;
  int m_shadow = CFG_RST;
  int m_active = CFG_RST;
  int m_phase  = PH_IDLE;
  int m_cnt    = 0;
  bit m_to     = 1'b0;

  // Model: one pipeline step of the request, then the frame-sequencing rules.
  always @(posedge clk or negedge rst_n) begin : model
    int  ph;
    bit  fire;
    if (!rst_n) begin
      m_req    <= CFG_RST;
      m_shadow <= CFG_RST;
      m_active <= CFG_RST;
      m_phase  <= PH_IDLE;
      m_cnt    <= 0;
      m_to     <= 1'b0;
    end else begin
      ph   = m_phase;
      fire = 1'b0;
      case (m_phase)
        PH_IDLE:   if (m_shadow != m_active) ph = eof ? PH_DRAIN : PH_WAIT;
        PH_WAIT:   if (m_shadow == m_active) ph = PH_IDLE; else if (eof) ph = PH_DRAIN;
        PH_DRAIN: begin
          if (pipe_idle) ph = PH_ARM;
`ifdef CFG_DRAIN_TIMEOUT_EN
          else if (m_cnt == TO_CYC - 1) begin
            ph   = PH_ARM;
            fire = 1'b1;
          end
`endif
        end
        PH_ARM:    if (sof) ph = PH_COMMIT;
        default:   ph = PH_IDLE;
      endcase
      if (m_phase == PH_ARM && sof) m_active <= m_shadow;
      if (m_phase != PH_COMMIT) m_shadow <= m_req;
      m_req   <= pack_cfg(req_mode, req_gauss, req_sobel, req_thr);
      m_cnt   <= (m_phase == PH_DRAIN && ph == PH_DRAIN) ? m_cnt + 1 : 0;
      m_phase <= ph;
      m_to    <= fire;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    int em;
    em = (m_active >> 10) & 1;
    chk("mode", int'(o_mode), em);
    chk("gaussian_en", int'(o_gaussian_en), ((m_active >> 9) & 1) & em);
    chk("sobel_en", int'(o_sobel_en), ((m_active >> 8) & 1) & em);
    chk("threshold", int'(o_threshold), m_active & 255);
    chk("pipe_flush", int'(o_pipe_flush), int'(m_phase == PH_DRAIN || m_phase == PH_ARM));
    chk("busy", int'(o_busy), int'(m_phase == PH_WAIT || m_phase == PH_DRAIN || m_phase == PH_ARM));
    chk("applied", int'(o_applied), int'(m_phase == PH_COMMIT));
    chk("drain_timeout", int'(o_drain_timeout), int'(m_to));
    if (o_applied) applied_cnt++;
    if (o_pipe_flush) flush_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic m, input logic g, input logic s, input logic [7:0] t);
    req_mode  = m;
    req_gauss = g;
    req_sobel = s;
    req_thr   = t;
  endtask

  initial begin : stim
    int base_applied;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 8'd25);
    sof = 1'b0; eof = 1'b0; pipe_idle = 1'b0;
    cyc(2);
    chk("rst_threshold", int'(o_threshold), 25);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_mode", int'(o_mode), 0);
    #3 rst_n = 1'b1;
    cyc(2);

    // 1: mode+sobel request, flush from DRAIN through ARM, single commit after SOF
    base_applied = applied_cnt;
    set_req(1'b1, 1'b0, 1'b1, 8'd25);
    cyc(3);
    chk("t1_pending_busy", int'(o_busy), 1);
    chk("t1_pending_noflush", int'(o_pipe_flush), 0);
    eof = 1'b1; cyc(1); eof = 1'b0;
    chk("t1_drain_flush", int'(o_pipe_flush), 1);
    cyc(5);
    chk("t1_drain_hold_mode", int'(o_mode), 0);
    pipe_idle = 1'b1; cyc(1);
    chk("t1_arm_flush", int'(o_pipe_flush), 1);
    sof = 1'b1; cyc(1); sof = 1'b0;
    chk("t1_commit_applied", int'(o_applied), 1);
    chk("t1_commit_sobel", int'(o_sobel_en), 1);
    chk("t1_commit_flush", int'(o_pipe_flush), 0);
    cyc(2);
    chk("t1_applied_once", applied_cnt - base_applied, 1);
    chk("t1_idle_busy", int'(o_busy), 0);

    // 2: threshold clamp with shortest path (EOF seen in IDLE), then reset default
    set_req(1'b1, 1'b0, 1'b1, 8'd150);
    cyc(2);
    eof = 1'b1; cyc(1); eof = 1'b0;
    chk("t2_direct_drain", int'(o_pipe_flush), 1);
    cyc(1);
    sof = 1'b1; cyc(1); sof = 1'b0;
    chk("t2_clamped_thr", int'(o_threshold), 100);
    chk("t2_applied", int'(o_applied), 1);
    pipe_idle = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t2_reset_thr", int'(o_threshold), 25);
    chk("t2_reset_sobel", int'(o_sobel_en), 0);
    set_req(1'b0, 1'b0, 1'b0, 8'd25);
    cyc(1);
    #3 rst_n = 1'b1;
    cyc(2);

    // 3: request reverted before EOF, no flush and no commit
    base_applied = applied_cnt;
    flush_cnt = 0;
    set_req(1'b0, 1'b1, 1'b0, 8'd25);
    cyc(3);
    chk("t3_pending", int'(o_busy), 1);
    set_req(1'b0, 1'b0, 1'b0, 8'd25);
    cyc(3);
    chk("t3_back_idle", int'(o_busy), 0);
    cyc(2);
    chk("t3_no_flush", flush_cnt, 0);
    chk("t3_no_apply", applied_cnt - base_applied, 0);

    // 4: SOF during DRAIN ignored; SOF+EOF together in ARM commits
    set_req(1'b1, 1'b1, 1'b0, 8'd25);
    cyc(3);
    eof = 1'b1; cyc(1); eof = 1'b0;
    sof = 1'b1; cyc(1); sof = 1'b0;
    chk("t4_sof_in_drain", int'(o_applied), 0);
    chk("t4_still_flush", int'(o_pipe_flush), 1);
    cyc(2);
    pipe_idle = 1'b1; cyc(1); pipe_idle = 1'b0;
    sof = 1'b1; eof = 1'b1; cyc(1); sof = 1'b0; eof = 1'b0;
    chk("t4_commit", int'(o_applied), 1);
    chk("t4_gauss_en", int'(o_gaussian_en), 1);
    cyc(1);

    // 5: change in ARM joins the commit; change during COMMIT commits one frame later
    set_req(1'b1, 1'b1, 1'b1, 8'd25);
    cyc(3);
    eof = 1'b1; cyc(1); eof = 1'b0;
    pipe_idle = 1'b1; cyc(1);
    set_req(1'b1, 1'b1, 1'b1, 8'd30);
    cyc(2);
    sof = 1'b1; cyc(1); sof = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 8'd40);
    chk("t5_thr30", int'(o_threshold), 30);
    chk("t5_sobel", int'(o_sobel_en), 1);
    cyc(3);
    chk("t5_rebusy", int'(o_busy), 1);
    chk("t5_thr_hold", int'(o_threshold), 30);
    eof = 1'b1; cyc(1); eof = 1'b0;
    cyc(1);
    sof = 1'b1; cyc(1); sof = 1'b0;
    chk("t5_thr40", int'(o_threshold), 40);
    cyc(1);
    pipe_idle = 1'b0;

`ifdef CFG_DRAIN_TIMEOUT_EN
    // Watchdog: pipe never idles, timeout pulse 16 clocks after DRAIN entry, then commit
    begin : wd
      int n;
      set_req(1'b1, 1'b1, 1'b1, 8'd60);
      cyc(3);
      eof = 1'b1; cyc(1); eof = 1'b0;
      n = 0;
      for (int i = 1; i <= 24; i++) begin
        cyc(1);
        if (o_drain_timeout) begin
          n = i;
          break;
        end
      end
      chk("wd_latency", n, TO_CYC);
      chk("wd_arm_flush", int'(o_pipe_flush), 1);
      sof = 1'b1; cyc(1); sof = 1'b0;
      chk("wd_commit_thr", int'(o_threshold), 60);
      cyc(1);
    end
`endif

    // 6: reset mid-DRAIN returns outputs at once and drops the pending change
    set_req(1'b1, 1'b1, 1'b0, 8'd40);
    cyc(3);
    eof = 1'b1; cyc(1); eof = 1'b0;
    cyc(2);
    chk("t6_in_drain", int'(o_pipe_flush), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flush", int'(o_pipe_flush), 0);
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_mode", int'(o_mode), 0);
    chk("t6_rst_gauss", int'(o_gaussian_en), 0);
    chk("t6_rst_thr", int'(o_threshold), 25);
    set_req(1'b0, 1'b0, 1'b0, 8'd25);
    cyc(2);
    #3 rst_n = 1'b1;
    cyc(4);
    chk("t6_after_busy", int'(o_busy), 0);
    chk("t6_after_applied", int'(o_applied), 0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
